and_share_arbiter: RTL and testbench

- Controller sharing one WIDTH-bit bitwise-AND datapath among NREQ requesters.
- Round-robin arbitration selects one requester at a time and captures its operand pair.
- Sequences the AND datapath and returns a registered result on a single response channel tagged with the requester ID.
- Sits between the requesting blocks and the shared AND unit at the top level.

---
 rtl/and_share_arbiter_pkg.sv | 23 ++
 rtl/and_share_arbiter_rr_pick.sv | 40 ++++
 rtl/and_share_arbiter.sv | 126 ++++++++++++
 tb/tb_and_share_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/and_share_arbiter_pkg.sv
// and_share_arbiter_pkg: shared FSM encoding, default sizes and ID-width helper
// Rev 1.0
`default_nettype none

package and_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_NREQ  = 2;

  // A single requester still needs a 1-bit ID field.
  function automatic int idw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/and_share_arbiter_rr_pick.sv
// and_share_arbiter_rr_pick: combinational round-robin pick starting at ptr
// Rev 1.0
`default_nettype none

module and_share_arbiter_rr_pick #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req_valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_oh_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            any_o
);

  int   idx;
  logic found;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      if (!found && req_valid_i[idx]) begin
        found          = 1'b1;
        gnt_idx_o      = IDW'(idx);
        gnt_oh_o[idx]  = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

`default_nettype wire

// File: rtl/and_share_arbiter.sv
// and_share_arbiter: round-robin sharing of one bitwise-AND unit among NREQ
// requesters with a single ID-tagged response channel. Rev 1.0
`default_nettype none

module and_share_arbiter
  import and_share_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int IDW   = idw_f(NREQ),
  parameter int CNTW  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  input  logic                  rsp_ready,
  output logic                  busy,
  output logic [CNTW-1:0]       done_cnt
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CNTW-1:0]  done_cnt_q, done_cnt_d;

  logic [NREQ-1:0]  pick_oh;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;

  and_share_arbiter_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_valid_i (req_valid),
    .ptr_i       (ptr_q),
    .gnt_oh_o    (pick_oh),
    .gnt_idx_o   (pick_idx),
    .any_o       (pick_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_id_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_id_q    <= gnt_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_id_d    = gnt_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    done_cnt_d  = done_cnt_q;
    req_ready   = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          req_ready = pick_oh;
          op_a_d    = req_a[pick_idx*WIDTH +: WIDTH];
          op_b_d    = req_b[pick_idx*WIDTH +: WIDTH];
          gnt_id_d  = pick_idx;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = op_a_q & op_b_q;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Pointer moves only on completion so the served requester drops to lowest priority.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 1'b1;
          ptr_d       = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign done_cnt  = done_cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_and_share_arbiter.sv
// tb_and_share_arbiter: directed stimulus with a queue-based response scoreboard
// Rev 1.0
`default_nettype none

module tb_and_share_arbiter;

  localparam int WIDTH = 4;
  localparam int NREQ  = 2;
  localparam int IDW   = 1;
  localparam int CNTW  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_ready = 1'b0;
  logic                  busy;
  logic [CNTW-1:0]       done_cnt;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  and_share_arbiter #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ),
    .IDW   (IDW),
    .CNTW  (CNTW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endfunction

  // Monitor: every completed handshake must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp actual id=%0d data=%0h required none", rsp_id, rsp_data);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic [3:0] a, input logic [3:0] b);
    req_valid[i]           = v;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic push_exp(input logic [IDW-1:0] id, input logic [WIDTH-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Returns at the negedge of the accept cycle; c = cycle stamp.
  task automatic wait_accept(output int c);
    bit ok;
    ok = 1'b0;
    c  = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (|req_ready) begin
        ok = 1'b1;
        c  = cyc;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_rsp_data"},  32'(rsp_data),  32'd0);
    chk({tag, "_done_cnt"},  32'(done_cnt),  32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    int c0, c1, cv;
    bool_dummy_init: begin end
    // Reset state
    #2;
    check_zero("reset");
    do_reset();

    // T1: single request, AND C&A = 8
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'hC, 4'hA);
    push_exp(1'd0, 4'h8);
    wait_accept(c0);
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 4'h0, 4'h0);
    cv = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        cv = cyc;
        break;
      end
    end
    chk("t1_latency", 32'(cv - c0), 32'd2);
    wait_drain();
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);

    // T2: both valid continuously from ptr=0: ids 0,1,0,1 data 3,5,3,5
    do_reset();
    push_exp(1'd0, 4'h3);
    push_exp(1'd1, 4'h5);
    push_exp(1'd0, 4'h3);
    push_exp(1'd1, 4'h5);
    set_req(0, 1'b1, 4'hF, 4'h3);
    set_req(1, 1'b1, 4'hF, 4'h5);
    c0 = 0;
    for (int k = 0; k < 4; k++) begin
      wait_accept(c1);
      if (k > 0) chk("t2_accept_spacing", 32'(c1 - c0), 32'd3);
      c0 = c1;
      @(posedge clk);
      #1;
    end
    set_req(0, 1'b0, 4'h0, 4'h0);
    set_req(1, 1'b0, 4'h0, 4'h0);
    wait_drain();
    chk("t2_done_cnt", 32'(done_cnt), 32'd4);

    // T3: backpressure on a 6&3=2 response for requester 0 (ptr=0)
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 4'h6, 4'h3);
    push_exp(1'd0, 4'h2);
    wait_accept(c0);
    chk("t3_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 4'h0, 4'h0);
    set_req(1, 1'b1, 4'h1, 4'h1);
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    for (int n = 0; n < 5; n++) begin
      chk("t3_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t3_hold_data",  32'(rsp_data),  32'h2);
      chk("t3_hold_id",    32'(rsp_id),    32'd0);
      chk("t3_hold_ready", 32'(req_ready), 32'd0);
      chk("t3_hold_busy",  32'(busy),      32'd1);
      @(negedge clk);
    end
    set_req(1, 1'b0, 4'h0, 4'h0);
    rsp_ready = 1'b1;
    wait_drain();
    chk("t3_done_cnt", 32'(done_cnt), 32'd5);

    // T4: reset during EXEC aborts; next grant goes to requester 0
    set_req(1, 1'b1, 4'hF, 4'hF);
    wait_accept(c0);
    chk("t4_req_ready", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 4'h0, 4'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("t4_async");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 4'h9, 4'hB);
    set_req(1, 1'b1, 4'hF, 4'h6);
    push_exp(1'd0, 4'h9);
    wait_accept(c0);
    chk("t4_regrant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 4'h0, 4'h0);
    set_req(1, 1'b0, 4'h0, 4'h0);
    wait_drain();
    chk("t4_done_cnt", 32'(done_cnt), 32'd1);

    // T5: 256 completions wrap the counter back to 0
    do_reset();
    for (int i = 0; i < 256; i++) begin
      set_req(0, 1'b1, 4'(i), 4'hF);
      push_exp(1'd0, 4'(i));
      wait_accept(c0);
      if (i == 255) chk("t5_cnt_255", 32'(done_cnt), 32'd255);
      @(posedge clk);
      #1;
    end
    set_req(0, 1'b0, 4'h0, 4'h0);
    wait_drain();
    chk("t5_wrap", 32'(done_cnt), 32'd0);

    // T6: only requester 1 valid with ptr=0, then a simultaneous request picks 0
    do_reset();
    set_req(1, 1'b1, 4'h7, 4'hE);
    push_exp(1'd1, 4'h6);
    wait_accept(c0);
    chk("t6_skip", 32'(req_ready), 32'h2);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 4'h0, 4'h0);
    wait_drain();
    set_req(0, 1'b1, 4'h5, 4'h4);
    set_req(1, 1'b1, 4'h3, 4'h1);
    push_exp(1'd0, 4'h4);
    wait_accept(c0);
    chk("t6_wrap_ptr", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 4'h0, 4'h0);
    set_req(1, 1'b0, 4'h0, 4'h0);
    wait_drain();
    chk("t6_done_cnt", 32'(done_cnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
